stopwatch_counter: RTL and testbench

Time-base and BCD counting core of the stopwatch. It divides the system clock into a 0.01 s tick and runs a start/stop/clear state machine. It maintains four BCD digits (SS.hh, 00.00–99.99 s) that feed the 4-digit multiplexed display driver directly. The digit outputs are registered and stable between ticks, so the display stage can sample them on its own scan clock.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd_digit.sv | 27 ++
 rtl/stopwatch_counter.sv | 122 ++++++++++++
 tb/tb_stopwatch_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counting core: FSM state encoding
// and BCD digit constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch cascade. carry is combinational so the
// whole chain rolls over on the same edge that consumes the tick.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  assign carry = inc & (value == BCD_MAX);

  // Digit register: clear has priority, otherwise count 0..9 on inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and BCD counter: button synchronizers with rising-edge
// detect, 0.01 s prescaler, start/stop/clear FSM and four cascaded digits.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | stopped at 00.00, prescaler and overflow flag held at 0
// RUN   | prescaler running, digits advance on every tick
// PAUSE | prescaler and digits frozen, resume keeps partial period
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_clr,
  output logic [BCD_W-1:0] num1,
  output logic [BCD_W-1:0] num2,
  output logic [BCD_W-1:0] num3,
  output logic [BCD_W-1:0] num4,
  output logic             running,
  output logic             ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [2:0] ss_sync;
  logic [2:0] clr_sync;
  logic       ss_ev;
  logic       clr_ev;

  sw_state_e  state;
  sw_state_e  state_nxt;

  logic [PW-1:0] presc;
  logic          tick;
  logic          digit_clr;
  logic          c4, c3, c2, c1;

  // Two synchronizer flops plus one history flop per button; reset to 0 so
  // a button held through reset release does not fire an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync  <= '0;
      clr_sync <= '0;
    end else begin
      ss_sync  <= {ss_sync[1:0], btn_ss};
      clr_sync <= {clr_sync[1:0], btn_clr};
    end
  end

  assign ss_ev  = ss_sync[1] & ~ss_sync[2];
  assign clr_ev = clr_sync[1] & ~clr_sync[2];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; clear beats start/stop only in PAUSE, and is dropped
  // in RUN so a stray press cannot lose a running time.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_ev) state_nxt = RUN;
      RUN:     if (ss_ev) state_nxt = PAUSE;
      PAUSE: begin
        if (clr_ev)     state_nxt = IDLE;
        else if (ss_ev) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // running is registered from the next state so it changes on the same
  // edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
    end
  end

  assign tick      = (state == RUN) && (presc == PRESC_LAST);
  assign digit_clr = (state_nxt == IDLE);

  // Prescaler: zero in (and on entry to) IDLE, counts only in RUN, holds in
  // PAUSE. A tick on the RUN->PAUSE edge is still consumed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (digit_clr) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_digit u_num4 (.clk(clk), .rst(rst), .inc(tick), .clr(digit_clr), .value(num4), .carry(c4));
  bcd_digit u_num3 (.clk(clk), .rst(rst), .inc(c4),   .clr(digit_clr), .value(num3), .carry(c3));
  bcd_digit u_num2 (.clk(clk), .rst(rst), .inc(c3),   .clr(digit_clr), .value(num2), .carry(c2));
  bcd_digit u_num1 (.clk(clk), .rst(rst), .inc(c2),   .clr(digit_clr), .value(num1), .carry(c1));

  // Sticky overflow: set when the top digit rolls 9->0, cleared on IDLE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (digit_clr) begin
      ovf <= 1'b0;
    end else if (c1) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a behavioural model tracks the elapsed count
// as an integer; its expected outputs are queued on each clock edge and
// compared against the DUT on the following falling edge.
module tb_stopwatch_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] num1, num2, num3, num4;
  logic       running, ovf;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r;
    r[15:12] = 4'((c / 1000) % 10);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  // Reference model: 0 idle, 1 run, 2 pause.
  typedef struct packed {
    logic [15:0] digits;
    logic        run;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   m_state = 0;
  int   m_presc = 0;
  int   m_count = 0;
  logic m_ovf = 1'b0;
  logic [2:0] m_ss = '0;
  logic [2:0] m_clr = '0;

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_state = 0; m_presc = 0; m_count = 0; m_ovf = 1'b0;
      m_ss = '0; m_clr = '0;
      sb.delete();
    end else begin
      logic ss_e, clr_e, tk;
      int   ns;
      ss_e  = m_ss[1] & ~m_ss[2];
      clr_e = m_clr[1] & ~m_clr[2];
      tk    = (m_state == 1) && (m_presc == TD - 1);
      ns    = m_state;
      if (m_state == 0 && ss_e) ns = 1;
      else if (m_state == 1 && ss_e) ns = 2;
      else if (m_state == 2 && clr_e) ns = 0;
      else if (m_state == 2 && ss_e) ns = 1;
      if (tk) begin
        m_count++;
        if (m_count == 10000) begin
          m_count = 0;
          m_ovf = 1'b1;
        end
      end
      if (ns == 0) begin
        m_count = 0; m_ovf = 1'b0; m_presc = 0;
      end else if (m_state == 1) begin
        m_presc = tk ? 0 : m_presc + 1;
      end
      m_state = ns;
      m_ss  = {m_ss[1:0], btn_ss};
      m_clr = {m_clr[1:0], btn_clr};
    end
    e.digits = to_bcd(m_count);
    e.run    = (m_state == 1);
    e.ovf    = m_ovf;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_digits", {16'h0, num1, num2, num3, num4}, {16'h0, e.digits});
      chk("sb_running", {31'h0, running}, {31'h0, e.run});
      chk("sb_ovf", {31'h0, ovf}, {31'h0, e.ovf});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic ss, input logic cl);
    @(negedge clk);
    btn_ss = ss;
    btn_clr = cl;
    @(negedge clk);
    btn_ss = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic wait_run(input logic want, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (running === want) break;
    end
    chk(tag, {31'h0, running}, {31'h0, want});
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_digits", {16'h0, num1, num2, num3, num4}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);

    // Start: button raised before edge k, not yet running after edge k+1.
    @(negedge clk);
    btn_ss = 1'b1;
    cyc(2);
    btn_ss = 1'b0;
    chk("start_not_early", {31'h0, running}, 32'h0);
    wait_run(1'b1, 3, "start_latency");
    cyc(TD - 1);
    chk("first_tick_before", {28'h0, num4}, 32'h0);
    cyc(1);
    chk("first_tick", {28'h0, num4}, 32'h1);
    cyc(9 * TD);
    chk("ten_ticks", {16'h0, num1, num2, num3, num4}, 32'h0010);

    // Pause / resume with a partial period in flight.
    cyc(1);
    press(1'b1, 1'b0);
    wait_run(1'b0, 6, "pause");
    cyc(20);
    press(1'b1, 1'b0);
    wait_run(1'b1, 6, "resume");
    cyc(15);

    // Clear while running is ignored, then stop and clear.
    press(1'b0, 1'b1);
    cyc(6);
    chk("clr_in_run", {31'h0, running}, 32'h1);
    press(1'b1, 1'b0);
    wait_run(1'b0, 6, "stop");
    press(1'b0, 1'b1);
    cyc(5);
    chk("cleared_digits", {16'h0, num1, num2, num3, num4}, 32'h0);
    chk("cleared_ovf", {31'h0, ovf}, 32'h0);

    // Simultaneous in IDLE: start wins; in PAUSE: clear wins.
    press(1'b1, 1'b1);
    wait_run(1'b1, 6, "both_idle");
    cyc(3 * TD + 1);
    press(1'b1, 1'b0);
    wait_run(1'b0, 6, "stop2");
    cyc(3);
    press(1'b1, 1'b1);
    cyc(6);
    chk("both_pause_run", {31'h0, running}, 32'h0);
    chk("both_pause_digits", {16'h0, num1, num2, num3, num4}, 32'h0);

    // Full wrap: 10000 ticks from 00.00.
    press(1'b1, 1'b0);
    wait_run(1'b1, 6, "wrap_start");
    cyc(10000 * TD - 1);
    chk("pre_wrap", {16'h0, num1, num2, num3, num4}, 32'h9999);
    chk("pre_wrap_ovf", {31'h0, ovf}, 32'h0);
    cyc(1);
    chk("wrap_digits", {16'h0, num1, num2, num3, num4}, 32'h0);
    chk("wrap_ovf", {31'h0, ovf}, 32'h1);
    chk("wrap_running", {31'h0, running}, 32'h1);
    press(1'b1, 1'b0);
    wait_run(1'b0, 6, "wrap_stop");
    press(1'b0, 1'b1);
    cyc(5);
    chk("wrap_clr_ovf", {31'h0, ovf}, 32'h0);

    // Held button: one transition only.
    @(negedge clk);
    btn_ss = 1'b1;
    cyc(50);
    btn_ss = 1'b0;
    cyc(5);
    chk("held_once", {31'h0, running}, 32'h1);

    // Asynchronous reset mid-period.
    cyc(2 * TD + 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_digits", {16'h0, num1, num2, num3, num4}, 32'h0);
    chk("async_running", {31'h0, running}, 32'h0);
    chk("async_ovf", {31'h0, ovf}, 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("post_rst_idle", {31'h0, running}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
